// File: rtl/alu_pipe_pkg.sv
// Shared opcode/func encodings and multiplier FSM states for the execute-stage ALU.
package alu_pipe_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier, one multiplier bit per cycle; signed ops run on magnitudes.
module alu_mul_seq
    import alu_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_cnt;
    logic               r_run;
    logic               r_neg;
    logic               r_done;
    logic [2*WIDTH-1:0] r_prod;

    logic [WIDTH-1:0]   w_ma;
    logic [WIDTH-1:0]   w_mb;
    logic [2*WIDTH-1:0] w_step_acc;

    assign w_ma       = (signed_op && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    assign w_mb       = (signed_op && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    assign w_step_acc = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // The load cycle already consumes multiplier bit 0, so WIDTH-1 further steps follow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_run    <= 1'b0;
            r_neg    <= 1'b0;
            r_done   <= 1'b0;
            r_prod   <= '0;
        end else if (start) begin
            r_acc    <= w_mb[0] ? {{WIDTH{1'b0}}, w_ma} : '0;
            r_mcand  <= {{(WIDTH-1){1'b0}}, w_ma, 1'b0};
            r_mplier <= w_mb >> 1;
            r_cnt    <= CW'(1);
            r_run    <= 1'b1;
            r_neg    <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_done   <= 1'b0;
        end else if (r_run) begin
            r_acc    <= w_step_acc;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
            if (r_cnt == CW'(WIDTH-1)) begin
                r_run  <= 1'b0;
                r_done <= 1'b1;
                r_prod <= r_neg ? (~w_step_acc + (2*WIDTH)'(1)) : w_step_acc;
            end
        end
    end

    assign done = r_done;
    assign prod = r_prod;

endmodule

// File: rtl/alu_pipe.sv
// Registered MIPS execute-stage ALU with valid/ready on both sides and sequential HI/LO multiply.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned SA_W      = $clog2(WIDTH),
    parameter bit          WORD_ADDR = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  op_a,
    input  logic [WIDTH-1:0]  op_b,
    input  logic [5:0]        opcode,
    input  logic [5:0]        func,
    input  logic [SA_W-1:0]   sa,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic              zero,
    output logic              negative,
    output logic              overflow,
    output logic              illegal,
    output logic              busy,
    output logic [WIDTH-1:0]  hi,
    output logic [WIDTH-1:0]  lo
);

    localparam logic [WIDTH-1:0] IMM_MASK = WIDTH'(32'h0000_FFFF);

    mul_state_t         r_state, w_state_nxt;
    logic               r_out_valid, r_zero, r_neg, r_ovf, r_ill;
    logic [WIDTH-1:0]   r_result, r_hi, r_lo;

    logic [WIDTH-1:0]   w_res, w_sum, w_negb, w_diff, w_addr, w_imm;
    logic               w_ovf, w_ill, w_is_mult, w_mul_signed;
    logic               w_add_ovf, w_sub_ovf;
    logic               w_slot_free, w_accept, w_load_alu, w_load_mul;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_prod;

    assign w_slot_free = !r_out_valid || out_ready;
    assign in_ready    = (r_state == IDLE) && w_slot_free;
    assign w_accept    = in_valid && in_ready;
    assign w_load_alu  = w_accept && !w_is_mult;
    assign w_load_mul  = (r_state == DONE) && w_slot_free;

    assign w_sum     = op_a + op_b;
    assign w_negb    = ~op_b + WIDTH'(1);
    assign w_diff    = op_a + w_negb;
    assign w_add_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1])  && (w_sum[WIDTH-1]  != op_a[WIDTH-1]);
    assign w_sub_ovf = (op_a[WIDTH-1] == w_negb[WIDTH-1]) && (w_diff[WIDTH-1] != op_a[WIDTH-1]);
    assign w_imm     = op_b & IMM_MASK;
    assign w_addr    = WORD_ADDR ? (op_a + $unsigned($signed(op_b) >>> 2)) : w_sum;

    // Operation decode and compute; shifts operate on rt (op_b).
    always_comb begin
        w_res        = '0;
        w_ovf        = 1'b0;
        w_ill        = 1'b0;
        w_is_mult    = 1'b0;
        w_mul_signed = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (func)
                    FN_SLL:   w_res = op_b << sa;
                    FN_SRL:   w_res = op_b >> sa;
                    FN_SRA:   w_res = $unsigned($signed(op_b) >>> sa);
                    FN_SLLV:  w_res = op_b << op_a[SA_W-1:0];
                    FN_SRLV:  w_res = op_b >> op_a[SA_W-1:0];
                    FN_SRAV:  w_res = $unsigned($signed(op_b) >>> op_a[SA_W-1:0]);
                    FN_JR:    w_res = op_a;
                    FN_MFHI:  w_res = r_hi;
                    FN_MFLO:  w_res = r_lo;
                    FN_MULT:  begin w_is_mult = 1'b1; w_mul_signed = 1'b1; end
                    FN_MULTU: w_is_mult = 1'b1;
                    FN_ADD:   begin w_res = w_sum;  w_ovf = w_add_ovf; end
                    FN_ADDU:  w_res = w_sum;
                    FN_SUB:   begin w_res = w_diff; w_ovf = w_sub_ovf; end
                    FN_SUBU:  w_res = w_diff;
                    FN_AND:   w_res = op_a & op_b;
                    FN_OR:    w_res = op_a | op_b;
                    FN_XOR:   w_res = op_a ^ op_b;
                    FN_NOR:   w_res = ~(op_a | op_b);
                    FN_SLT:   w_res = WIDTH'($signed(op_a) < $signed(op_b));
                    FN_SLTU:  w_res = WIDTH'(op_a < op_b);
                    default:  w_ill = 1'b1;
                endcase
            end
            OP_ADDI:  begin w_res = w_sum; w_ovf = w_add_ovf; end
            OP_ADDIU: w_res = w_sum;
            OP_ANDI:  w_res = op_a & w_imm;
            OP_ORI:   w_res = op_a | w_imm;
            OP_XORI:  w_res = op_a ^ w_imm;
            OP_BEQ:   w_res = WIDTH'(op_a == op_b);
            OP_BNE:   w_res = WIDTH'(op_a != op_b);
            OP_JAL:   w_res = op_a;
            OP_LW,
            OP_SW:    w_res = w_addr;
            default:  w_ill = 1'b1;
        endcase
    end

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (w_accept && w_is_mult),
        .signed_op (w_mul_signed),
        .a         (op_a),
        .b         (op_b),
        .done      (w_mul_done),
        .prod      (w_prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept && w_is_mult) w_state_nxt = MUL;
            MUL:     if (w_mul_done)            w_state_nxt = DONE;
            DONE:    if (w_slot_free)           w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output stage: load on ALU accept or multiply completion, otherwise hold until drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_neg       <= 1'b0;
            r_ovf       <= 1'b0;
            r_ill       <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
        end else if (w_load_alu) begin
            r_out_valid <= 1'b1;
            r_result    <= w_res;
            r_zero      <= (w_res == '0);
            r_neg       <= w_res[WIDTH-1];
            r_ovf       <= w_ovf;
            r_ill       <= w_ill;
        end else if (w_load_mul) begin
            r_out_valid <= 1'b1;
            r_result    <= w_prod[WIDTH-1:0];
            r_zero      <= (w_prod[WIDTH-1:0] == '0);
            r_neg       <= w_prod[WIDTH-1];
            r_ovf       <= 1'b0;
            r_ill       <= 1'b0;
            r_hi        <= w_prod[2*WIDTH-1:WIDTH];
            r_lo        <= w_prod[WIDTH-1:0];
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign negative  = r_neg;
    assign overflow  = r_ovf;
    assign illegal   = r_ill;
    assign busy      = (r_state != IDLE);
    assign hi        = r_hi;
    assign lo        = r_lo;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe: ALU ops, handshake stalls, MULT/MULTU and mid-multiply reset.
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] op_a, op_b, result, hi, lo;
    logic [5:0]  opcode, func;
    logic [4:0]  sa;
    logic        zero, negative, overflow, illegal, busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .opcode(opcode), .func(func), .sa(sa),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .negative(negative), .overflow(overflow), .illegal(illegal),
        .busy(busy), .hi(hi), .lo(lo)
    );

    typedef struct {
        logic [5:0]  opc;
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  s;
        logic [31:0] res;
        logic        ovf;
        logic        ill;
    } vec_t;

    // Present one op at a negedge, let it be accepted, return at the following negedge.
    task automatic send(input logic [5:0] opc, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] s);
        opcode = opc; func = fn; op_a = a; op_b = b; sa = s;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (result !== 32'h0)   begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL reset_hilo got=%h exp=0", {hi, lo}); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_alu_ops();
        vec_t v[24];
        v[0]  = '{6'h00, 6'h20, 32'h7FFFFFFF, 32'h00000001, 5'd0, 32'h80000000, 1'b1, 1'b0}; // add
        v[1]  = '{6'h00, 6'h21, 32'h7FFFFFFF, 32'h00000001, 5'd0, 32'h80000000, 1'b0, 1'b0}; // addu
        v[2]  = '{6'h00, 6'h22, 32'h80000000, 32'h00000001, 5'd0, 32'h7FFFFFFF, 1'b1, 1'b0}; // sub
        v[3]  = '{6'h00, 6'h23, 32'h00000005, 32'h00000007, 5'd0, 32'hFFFFFFFE, 1'b0, 1'b0}; // subu
        v[4]  = '{6'h00, 6'h24, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hF000F000, 1'b0, 1'b0}; // and
        v[5]  = '{6'h00, 6'h25, 32'hF0F0F0F0, 32'h0F0F0000, 5'd0, 32'hFFFFF0F0, 1'b0, 1'b0}; // or
        v[6]  = '{6'h00, 6'h26, 32'hFFFF0000, 32'hFF00FF00, 5'd0, 32'h00FFFF00, 1'b0, 1'b0}; // xor
        v[7]  = '{6'h00, 6'h27, 32'h00000000, 32'h00000000, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0}; // nor
        v[8]  = '{6'h00, 6'h2A, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000001, 1'b0, 1'b0}; // slt
        v[9]  = '{6'h00, 6'h2B, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000000, 1'b0, 1'b0}; // sltu
        v[10] = '{6'h00, 6'h03, 32'h80000000, 32'h80000000, 5'd4, 32'hF8000000, 1'b0, 1'b0}; // sra
        v[11] = '{6'h00, 6'h00, 32'h00000000, 32'h00000003, 5'd4, 32'h00000030, 1'b0, 1'b0}; // sll
        v[12] = '{6'h00, 6'h02, 32'h00000000, 32'h80000000, 5'd31, 32'h00000001, 1'b0, 1'b0}; // srl
        v[13] = '{6'h00, 6'h07, 32'h00000008, 32'h80000000, 5'd0, 32'hFF800000, 1'b0, 1'b0}; // srav
        v[14] = '{6'h08, 6'h00, 32'h7FFFFFF0, 32'h00000010, 5'd0, 32'h80000000, 1'b1, 1'b0}; // addi
        v[15] = '{6'h0C, 6'h00, 32'hFFFFFFFF, 32'hFFFF1234, 5'd0, 32'h00001234, 1'b0, 1'b0}; // andi
        v[16] = '{6'h0D, 6'h00, 32'h00000000, 32'hFFFF8000, 5'd0, 32'h00008000, 1'b0, 1'b0}; // ori
        v[17] = '{6'h04, 6'h00, 32'h00000055, 32'h00000055, 5'd0, 32'h00000001, 1'b0, 1'b0}; // beq
        v[18] = '{6'h05, 6'h00, 32'h00000055, 32'h00000055, 5'd0, 32'h00000000, 1'b0, 1'b0}; // bne
        v[19] = '{6'h03, 6'h00, 32'h12345678, 32'h00000000, 5'd0, 32'h12345678, 1'b0, 1'b0}; // jal
        v[20] = '{6'h00, 6'h08, 32'hABCD0000, 32'h00000000, 5'd0, 32'hABCD0000, 1'b0, 1'b0}; // jr
        v[21] = '{6'h2B, 6'h00, 32'h00001000, 32'hFFFFFFFC, 5'd0, 32'h00000FFF, 1'b0, 1'b0}; // sw
        v[22] = '{6'h3F, 6'h00, 32'h11111111, 32'h22222222, 5'd0, 32'h00000000, 1'b0, 1'b1}; // bad opcode
        v[23] = '{6'h00, 6'h3F, 32'h11111111, 32'h22222222, 5'd0, 32'h00000000, 1'b0, 1'b1}; // bad func
        for (int i = 0; i < 24; i++) begin
            send(v[i].opc, v[i].fn, v[i].a, v[i].b, v[i].s);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL op%0d_valid got=%b exp=1", i, out_valid); end
            checks++; if (result !== v[i].res) begin errors++; $display("FAIL op%0d_result got=%h exp=%h", i, result, v[i].res); end
            checks++; if (overflow !== v[i].ovf) begin errors++; $display("FAIL op%0d_overflow got=%b exp=%b", i, overflow, v[i].ovf); end
            checks++; if (illegal !== v[i].ill) begin errors++; $display("FAIL op%0d_illegal got=%b exp=%b", i, illegal, v[i].ill); end
            checks++; if (zero !== (v[i].res == 32'h0)) begin errors++; $display("FAIL op%0d_zero got=%b exp=%b", i, zero, (v[i].res == 32'h0)); end
            checks++; if (negative !== v[i].res[31]) begin errors++; $display("FAIL op%0d_negative got=%b exp=%b", i, negative, v[i].res[31]); end
        end
    endtask

    task automatic test_back_to_back();
        int idx = 0, got = 0, last_cyc = -1;
        out_ready = 1'b1;
        @(negedge clk);
        opcode = 6'h00; func = 6'h21; op_b = 32'd100; sa = 5'd0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            out_ready = !(cyc >= 1 && cyc <= 3);
            in_valid  = (idx < 6);
            op_a      = 32'(idx);
            #1;
            if (out_valid && !out_ready) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", cyc, in_ready); end
                checks++; if (result !== 32'(100 + got)) begin errors++; $display("FAIL stall_hold cyc=%0d got=%h exp=%h", cyc, result, 32'(100 + got)); end
            end
            if (out_valid && out_ready) begin
                checks++; if (result !== 32'(100 + got)) begin errors++; $display("FAIL b2b_result n=%0d got=%h exp=%h", got, result, 32'(100 + got)); end
                got++;
                last_cyc = cyc;
            end
            if (in_valid && in_ready) idx++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++; if (got !== 6) begin errors++; $display("FAIL b2b_count got=%0d exp=6", got); end
        checks++; if (last_cyc !== 9) begin errors++; $display("FAIL b2b_throughput last_cycle=%0d exp=9", last_cyc); end
    endtask

    task automatic test_mult();
        int cnt = 0;
        send(6'h00, 6'h18, 32'hFFFFFFFD, 32'h00000007, 5'd0);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mult_in_ready got=%b exp=0", in_ready); end
        while (busy && cnt < 100) begin cnt++; @(negedge clk); end
        checks++; if (cnt !== 33) begin errors++; $display("FAIL mult_busy_cycles got=%0d exp=33", cnt); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mult_valid got=%b exp=1", out_valid); end
        checks++; if (result !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_result got=%h exp=FFFFFFEB", result); end
        checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got=%h exp=FFFFFFFF", hi); end
        checks++; if (lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_lo got=%h exp=FFFFFFEB", lo); end
        send(6'h00, 6'h12, 32'h0, 32'h0, 5'd0);
        checks++; if (result !== 32'hFFFFFFEB) begin errors++; $display("FAIL mflo got=%h exp=FFFFFFEB", result); end
        send(6'h00, 6'h10, 32'h0, 32'h0, 5'd0);
        checks++; if (result !== 32'hFFFFFFFF) begin errors++; $display("FAIL mfhi got=%h exp=FFFFFFFF", result); end
        send(6'h00, 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0);
        cnt = 0;
        while (busy && cnt < 100) begin cnt++; @(negedge clk); end
        checks++; if (cnt !== 33) begin errors++; $display("FAIL multu_busy_cycles got=%0d exp=33", cnt); end
        checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi got=%h exp=FFFFFFFE", hi); end
        checks++; if (lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo got=%h exp=00000001", lo); end
        checks++; if (result !== 32'h00000001) begin errors++; $display("FAIL multu_result got=%h exp=00000001", result); end
    endtask

    task automatic test_reset_mid_mult();
        int seen = 0;
        send(6'h00, 6'h18, 32'h00000005, 32'h00000006, 5'd0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmul_valid got=%b exp=0", out_valid); end
        checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL rstmul_hilo got=%h exp=0", {hi, lo}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmul_busy got=%b exp=0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmul_in_ready got=%b exp=1", in_ready); end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid || busy) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rstmul_no_output cycles=%0d exp=0", seen); end
        send(6'h23, 6'h00, 32'd100, 32'd8, 5'd0);
        checks++; if (result !== 32'd102) begin errors++; $display("FAIL lw_addr got=%0d exp=102", result); end
        checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL lw_hilo got=%h exp=0", {hi, lo}); end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; opcode = '0; func = '0; sa = '0;
        test_reset();
        test_alu_ops();
        test_back_to_back();
        test_mult();
        test_reset_mid_mult();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
